// File: rtl/font_fetch_ctrl.sv
// Text-mode scanline renderer: fetches character codes and font rows, serialises pixels,
// and shares the single-port font ROM with a low-priority CPU read-back path.
module font_fetch_ctrl #(
  parameter int unsigned COLS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [4:0]  row,
  input  logic [2:0]  scan,
  output logic [10:0] vram_ad,
  input  logic [7:0]  vram_dout,
  output logic [10:0] font_ad,
  output logic        font_ce,
  input  logic [7:0]  font_dout,
  output logic        pix_valid,
  output logic        pix,
  input  logic        pix_ready,
  output logic        line_done,
  input  logic        cpu_req,
  input  logic [10:0] cpu_ad,
  output logic        cpu_ack,
  output logic [7:0]  cpu_data
);

  localparam logic [6:0] ColLast = 7'(COLS - 1);

  typedef enum logic [2:0] {
    StIdle, StVaddr, StVcap, StFaddr, StFcap, StShift
  } state_e;

  state_e      state_q;
  logic [4:0]  row_q;
  logic [2:0]  scan_q;
  logic [6:0]  col_q;
  logic [7:0]  code_q;
  logic [7:0]  shreg_q;
  logic [2:0]  bitcnt_q;
  logic        line_done_q;
  logic        cpu_p1_q;
  logic        cpu_ack_q;
  logic [7:0]  cpu_data_q;

  logic [11:0] lin_addr;
  logic        ren_issue;
  logic        cpu_issue;
  logic        xfer;

  assign lin_addr  = 12'(row_q) * 12'(COLS) + 12'(col_q);
  assign vram_ad   = lin_addr[10:0];

  // Renderer owns the ROM in FADDR; a CPU read waits while one is still in flight.
  assign ren_issue = (state_q == StFaddr);
  assign cpu_issue = cpu_req & ~cpu_p1_q & ~cpu_ack_q & ~ren_issue & ~reset;
  assign font_ce   = ren_issue | cpu_issue;

  always_comb begin
    font_ad = '0;
    if (ren_issue) begin
      font_ad = {code_q, scan_q};
    end else if (cpu_issue) begin
      font_ad = cpu_ad;
    end
  end

  assign pix_valid = (state_q == StShift);
  assign pix       = shreg_q[7];
  assign xfer      = pix_valid & pix_ready;
  assign line_done = line_done_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_data  = cpu_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      scan_q      <= '0;
      col_q       <= '0;
      code_q      <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (line_start) begin
            row_q   <= row;
            scan_q  <= scan;
            col_q   <= '0;
            state_q <= StVaddr;
          end
        end
        StVaddr: state_q <= StVcap;
        StVcap: begin
          code_q  <= vram_dout;
          state_q <= StFaddr;
        end
        StFaddr: state_q <= StFcap;
        StFcap: begin
          shreg_q  <= font_dout;
          bitcnt_q <= '0;
          state_q  <= StShift;
        end
        StShift: begin
          if (xfer) begin
            shreg_q  <= {shreg_q[6:0], 1'b0};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (col_q == ColLast) begin
                state_q     <= StIdle;
                line_done_q <= 1'b1;
              end else begin
                col_q   <= col_q + 7'd1;
                state_q <= StVaddr;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // CPU read pipeline: issue, ROM latency cycle, then ack with captured data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_p1_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_data_q <= '0;
    end else begin
      cpu_p1_q  <= cpu_issue;
      cpu_ack_q <= cpu_p1_q;
      if (cpu_p1_q) begin
        cpu_data_q <= font_dout;
      end
    end
  end

endmodule

// File: tb/tb_font_fetch_ctrl.sv
// Directed bench for font_fetch_ctrl with COLS=2: render timing, backpressure,
// CPU read-back, ROM collision, ignored line_start and asynchronous reset.
module tb_font_fetch_ctrl;

  localparam int unsigned COLS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [4:0]  row = 5'd3;
  logic [2:0]  scan = 3'd0;
  logic [10:0] vram_ad;
  logic [7:0]  vram_dout = 8'h00;
  logic [10:0] font_ad;
  logic        font_ce;
  logic [7:0]  font_dout = 8'h00;
  logic        pix_valid;
  logic        pix;
  logic        pix_ready = 1'b1;
  logic        line_done;
  logic        cpu_req = 1'b0;
  logic [10:0] cpu_ad = 11'h000;
  logic        cpu_ack;
  logic [7:0]  cpu_data;

  logic [7:0]  vram [2048];
  logic [7:0]  font [2048];

  int n_checks = 0;
  int n_pass = 0;

  int          n_xfer = 0;
  int          n_done = 0;
  int          n_ack = 0;
  logic [15:0] pixw = 16'h0;

  font_fetch_ctrl #(.COLS(COLS)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .row        (row),
    .scan       (scan),
    .vram_ad    (vram_ad),
    .vram_dout  (vram_dout),
    .font_ad    (font_ad),
    .font_ce    (font_ce),
    .font_dout  (font_dout),
    .pix_valid  (pix_valid),
    .pix        (pix),
    .pix_ready  (pix_ready),
    .line_done  (line_done),
    .cpu_req    (cpu_req),
    .cpu_ad     (cpu_ad),
    .cpu_ack    (cpu_ack),
    .cpu_data   (cpu_data)
  );

  always #5 clk = ~clk;

  // Synchronous RAM/ROM models: data valid the cycle after the address.
  always @(posedge clk) vram_dout <= vram[vram_ad];
  always @(posedge clk) if (font_ce) font_dout <= font[font_ad];

  // Passive monitor, sampled mid-cycle so values are settled.
  always @(negedge clk) begin
    if (!reset) begin
      if (pix_valid && pix_ready) begin
        pixw   <= {pixw[14:0], pix};
        n_xfer <= n_xfer + 1;
      end
      if (line_done) n_done <= n_done + 1;
      if (cpu_ack) n_ack <= n_ack + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, vram_ad, font_ad, font_ce, pix_valid, pix, line_done, cpu_ack, cpu_data};
  endfunction

  // One scanline from line_start; cycle c counts from the edge that samples line_start.
  task automatic run_line(input string tag, input int bp_at, input int ls_again, input int cpu_at,
                          input int cpu_hold, input logic [10:0] caddr, input int rst_at);
    int x0, d0, a0, ci;
    x0 = n_xfer;
    d0 = n_done;
    a0 = n_ack;
    ci = (cpu_at == 3) ? 4 : cpu_at;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      pix_ready  = !(bp_at > 0 && c >= bp_at && c < bp_at + 5);
      line_start = (c == ls_again);
      cpu_req    = (cpu_at > 0 && c >= cpu_at && c < cpu_at + cpu_hold);
      cpu_ad     = caddr;
      if (rst_at > 0 && c == rst_at + 2) reset = 1'b0;
      #1;
      if (rst_at == 0 || c < rst_at) begin
        if (c == 1) check_eq({tag, " vram_ad_c1"}, vram_ad, 11'd6);
        if (c == 3) check_eq({tag, " issue_c3"}, {font_ce, font_ad}, {1'b1, 11'h208});
        if (c == 4) check_eq({tag, " pv_c4"}, pix_valid, 1'b0);
        if (c == 5) check_eq({tag, " pv_c5"}, {pix_valid, pix}, 2'b10);
        if (bp_at == 0) begin
          if (c == 13) check_eq({tag, " vram_ad_c13"}, vram_ad, 11'd7);
          if (c == 16) check_eq({tag, " gap_c16"}, pix_valid, 1'b0);
          if (c == 17) check_eq({tag, " pv_c17"}, {pix_valid, pix}, 2'b10);
        end
        if (cpu_at > 0) begin
          if (c == ci) check_eq({tag, " cpu_issue"}, {font_ce, font_ad}, {1'b1, caddr});
          if (rst_at == 0 && c == ci + 1) check_eq({tag, " cpu_noack"}, cpu_ack, 1'b0);
          if (rst_at == 0 && c == ci + 2)
            check_eq({tag, " cpu_ack"}, {cpu_ack, cpu_data}, {1'b1, font[caddr]});
        end
      end
      if (bp_at > 0 && c >= bp_at && c < bp_at + 5)
        check_eq({tag, " bp_hold"}, {pix_valid, pix}, 2'b11);
      if (c == rst_at) begin
        #1 reset = 1'b1;
        #1 check_eq({tag, " rst_async"}, all_outs(), 64'd0);
      end
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
    cpu_req   = 1'b0;
    line_start = 1'b0;
    if (rst_at == 0) begin
      check_eq({tag, " xfers"}, n_xfer - x0, 16);
      check_eq({tag, " pixels"}, pixw, 16'h307C);
      check_eq({tag, " line_done"}, n_done - d0, 1);
      if (cpu_at > 0) check_eq({tag, " ack_count"}, n_ack - a0, 1);
    end else begin
      check_eq({tag, " no_done"}, n_done - d0, 0);
      check_eq({tag, " no_ack"}, n_ack - a0, 0);
      check_eq({tag, " idle_outs"}, {pix_valid, font_ce, cpu_ack}, 3'b000);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vram[i] = 8'(i + 16);
      font[i] = 8'(i * 13 + 7);
    end
    vram[6] = 8'h41;
    vram[7] = 8'h40;
    font[11'h208] = 8'h30;
    font[11'h209] = 8'h78;
    font[11'h200] = 8'h7C;
    font[11'h20A] = 8'hA5;

    // Reset state, with a CPU request present that must not leak through.
    cpu_req = 1'b1;
    cpu_ad  = 11'h123;
    #1 check_eq("reset_outs", all_outs(), 64'd0);
    @(posedge clk); #1;
    check_eq("reset_outs_clk", all_outs(), 64'd0);
    cpu_req = 1'b0;
    reset   = 1'b0;
    @(posedge clk); #1;

    run_line("render", 0, 0, 0, 0, 11'h000, 0);

    // CPU read with the renderer idle.
    cpu_req = 1'b1;
    cpu_ad  = 11'h209;
    #1 check_eq("cpu_idle_issue", {font_ce, font_ad}, {1'b1, 11'h209});
    @(posedge clk); #1;
    cpu_req = 1'b0;
    #1 check_eq("cpu_idle_i1", {font_ce, cpu_ack}, 2'b00);
    @(posedge clk); #1;
    check_eq("cpu_idle_ack", {cpu_ack, cpu_data}, {1'b1, 8'h78});
    @(posedge clk); #1;
    check_eq("cpu_idle_hold", {cpu_ack, cpu_data}, {1'b0, 8'h78});
    @(posedge clk); #1;

    run_line("backpressure", 7, 0, 0, 0, 11'h000, 0);
    run_line("collision", 0, 0, 3, 2, 11'h20A, 0);
    run_line("ls_ignored", 0, 6, 0, 0, 11'h000, 0);
    run_line("reset_mid", 0, 0, 6, 1, 11'h209, 7);
    run_line("after_reset", 0, 0, 0, 0, 11'h000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/font_fetch_ctrl.md
FONT_FETCH_CTRL -- requirements
Module: font_fetch_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 40, meaning characters per text row (1..80).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port line_start, input, 1, request to render one scanline.
REQ-005 SHALL have port row, input, 5, text row index, sampled with line_start.
REQ-006 SHALL have port scan, input, 3, pixel row within character, sampled with line_start.
REQ-007 SHALL have port vram_ad, output, 11, text RAM address.
REQ-008 SHALL have port vram_dout, input, 8, character code; valid the cycle after vram_ad.
REQ-009 SHALL have ports font_ad (output, 11) and font_ce (output, 1) driving the 2048x8 font ROM (oce tied high externally).
REQ-010 SHALL have port font_dout, input, 8, font row; valid the cycle after the issue cycle (font_ce=1).
REQ-011 SHALL have ports pix_valid (output, 1), pix (output, 1) and pix_ready (input, 1), a pixel stream.
REQ-012 SHALL have port line_done, output, 1, one-cycle pulse at scanline end.
REQ-013 SHALL have ports cpu_req (input, 1), cpu_ad (input, 11), cpu_ack (output, 1) and cpu_data (output, 8), a CPU font read-back port.

Function
REQ-014 SHALL use renderer FSM states IDLE, VADDR, VCAP, FADDR, FCAP and SHIFT.
REQ-015 In IDLE with line_start=1: SHALL latch row and scan, set col=0, and go to VADDR; line_start SHALL be ignored in every other state.
REQ-016 In VADDR: vram_ad SHALL be (row*COLS+col) mod 2048. Next state VCAP.
REQ-017 In VCAP: SHALL capture vram_dout as code. Next state FADDR.
REQ-018 In FADDR: SHALL drive font_ce=1 and font_ad={code,scan}, which is the renderer issue cycle. Next state FCAP.
REQ-019 In FCAP: SHALL load font_dout into an 8-bit shift register and set bitcnt=0. Next state SHIFT.
REQ-020 In SHIFT: pix_valid=1 and pix=shreg[7], MSB = leftmost pixel.
REQ-021 A transfer SHALL occur when pix_valid=1 and pix_ready=1.
REQ-022 With pix_ready=0, pix SHALL be held stable.
REQ-023 On each transfer, SHALL shift left and increment bitcnt.
REQ-024 On the 8th transfer with col<COLS-1: SHALL increment col and go to VADDR.
REQ-025 On the 8th transfer with col=COLS-1: SHALL go to IDLE and pulse line_done=1 in the next cycle.
REQ-026 Latency SHALL be: line_start sampled at edge E0, VADDR in cycle 1, FADDR in cycle 3, first pix_valid in cycle 5.
REQ-027 The gap between characters SHALL be exactly 4 cycles with pix_valid=0.
REQ-028 The CPU port SHALL be arbitrated as follows: a CPU issue cycle is the first cycle in which cpu_req=1, no CPU read is pending, and the FSM is not in FADDR.
REQ-029 In a CPU issue cycle I: font_ce=1 and font_ad=cpu_ad. SHALL capture font_dout at the end of I+1, then cpu_ack=1 for exactly cycle I+2 with cpu_data valid.
REQ-030 A CPU read SHALL be pending in cycles I..I+2; the next CPU issue SHALL be no earlier than I+3.
REQ-031 The renderer SHALL always win the issue cycle; a CPU read SHALL be delayed, never dropped.
REQ-032 font_ce SHALL be 0 in all cycles other than renderer or CPU issue cycles.
REQ-033 cpu_data SHALL hold its last value until the next ack.

Reset
REQ-034 reset=1 SHALL immediately force state IDLE, col=0, bitcnt=0, shreg=0, no pending CPU read, and outputs vram_ad=0, font_ad=0, font_ce=0, pix_valid=0, pix=0, line_done=0, cpu_ack=0, cpu_data=0.
REQ-035 Reset mid-line or mid-CPU-read SHALL abandon the operation with no ack and no line_done; after release the block SHALL be in IDLE.

Verification
REQ-036 Render: COLS=2, row=3, scan=0, VRAM[6]=0x41, VRAM[7]=0x40, pix_ready=1 -> vram_ad=6 in cycle 1, font_ad=0x208 in cycle 3, pixels 0,0,1,1,0,0,0,0 then 0,1,1,1,1,1,0,0, then a single line_done.
REQ-037 Backpressure: pix_ready=0 for 5 cycles at pixel 3 of 'A' -> pix held at 1, no pixel lost or duplicated, total of 16 transfers.
REQ-038 CPU read in IDLE: cpu_req=1, cpu_ad=0x209 in cycle I -> font_ce=1 in cycle I, cpu_ack=1 with cpu_data=0x78 in cycle I+2.
REQ-039 Collision: cpu_req first high in the FADDR cycle -> renderer issues in that cycle, CPU issues in the next cycle, ack one cycle later than uncontested, render output unchanged.
REQ-040 line_start pulsed again during SHIFT -> ignored; exactly one line_done.
REQ-041 Reset asserted during SHIFT and during a pending CPU read -> all outputs 0 asynchronously, no cpu_ack; a new line_start after release renders correctly from cycle 1.
